// File: rtl/crtc_pkg.sv
// Shared definitions for the CRTC character pixel generator: VRAM word layout,
// fetch state encoding, legal cell widths and the pixel colour selection.
package crtc_pkg;

   localparam int VRAM_DW    = 16;
   localparam int CODE_LSB   = 0;
   localparam int CODE_W     = 8;
   localparam int FG_LSB     = 8;
   localparam int BG_LSB     = 12;
   localparam int COLOR_W    = 4;

   localparam int CHAR_W_MIN = 3;
   localparam int CHAR_W_MAX = 16;

   localparam logic [1:0] FETCH_IDLE = 2'd0;
   localparam logic [1:0] FETCH_VADR = 2'd1;
   localparam logic [1:0] FETCH_CADR = 2'd2;
   localparam logic [1:0] FETCH_DONE = 2'd3;

   // Blanked cells always show colour 0 regardless of glyph or attributes.
   function automatic logic [COLOR_W-1:0] pick_color(input logic pix,
                                                     input logic [COLOR_W-1:0] fg,
                                                     input logic [COLOR_W-1:0] bg,
                                                     input logic de);
      if (!de) return '0;
      return pix ? fg : bg;
   endfunction

endpackage

// File: rtl/crtc_pix_shifter.sv
// Output stage: loads one glyph row per cell, shifts it out MSB-first on each
// pixel step and keeps colour, display enable and syncs aligned.
module crtc_pix_shifter
   import crtc_pkg::*;
#(
   parameter int CHAR_W = 8
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic               ce,
   input  logic               load,
   input  logic [CHAR_W-1:0]  load_glyph,
   input  logic [COLOR_W-1:0] load_fg,
   input  logic [COLOR_W-1:0] load_bg,
   input  logic               load_de,
   input  logic               load_hs,
   input  logic               load_vs,
   output logic [COLOR_W-1:0] color,
   output logic               hsync,
   output logic               vsync,
   output logic               de
);

   logic [CHAR_W-1:0]  shift_q, shift_d, src;
   logic [COLOR_W-1:0] fg_q, fg_d, bg_q, bg_d, color_q, color_d;
   logic               de_q, de_d, hs_q, hs_d, vs_q, vs_d;

   // The load edge emits pixel 0 of the new row directly, so the first pixel
   // appears in the same cycle as the new sync/enable values.
   always_comb begin
      src     = load ? load_glyph : shift_q;
      fg_d    = load ? load_fg : fg_q;
      bg_d    = load ? load_bg : bg_q;
      de_d    = load ? load_de : de_q;
      hs_d    = load ? load_hs : hs_q;
      vs_d    = load ? load_vs : vs_q;
      shift_d = shift_q;
      color_d = color_q;
      if (ce) begin
         shift_d = {src[CHAR_W-2:0], 1'b0};
         color_d = pick_color(src[CHAR_W-1], fg_d, bg_d, de_d);
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         shift_q <= '0;
         fg_q    <= '0;
         bg_q    <= '0;
         de_q    <= 1'b0;
         hs_q    <= 1'b0;
         vs_q    <= 1'b0;
         color_q <= '0;
      end else begin
         shift_q <= shift_d;
         fg_q    <= fg_d;
         bg_q    <= bg_d;
         de_q    <= de_d;
         hs_q    <= hs_d;
         vs_q    <= vs_d;
         color_q <= color_d;
      end
   end

   assign color = color_q;
   assign hsync = hs_q;
   assign vsync = vs_q;
   assign de    = de_q;

endmodule

// File: rtl/crtc_char_pixgen.sv
// Character-mode pixel generator behind a 6845-style CRTC: cell counter,
// VRAM/character-ROM fetch sequencer and the pixel output shifter.
module crtc_char_pixgen
   import crtc_pkg::*;
#(
   parameter int CHAR_W  = 8,
   parameter int VRAM_AW = 11,
   parameter int ROW_W   = 3
) (
   input  logic                  I_CLK,
   input  logic                  I_RSTn,
   input  logic                  I_PIX_CE,
   output logic                  O_CHR_CE,
   input  logic [13:0]           I_MA,
   input  logic [4:0]            I_RA,
   input  logic                  I_DISPTMG,
   input  logic                  I_HSYNC,
   input  logic                  I_VSYNC,
   output logic [VRAM_AW-1:0]    O_VRAM_A,
   input  logic [VRAM_DW-1:0]    I_VRAM_D,
   output logic [8+ROW_W-1:0]    O_CROM_A,
   input  logic [CHAR_W-1:0]     I_CROM_D,
   output logic [COLOR_W-1:0]    O_COLOR,
   output logic                  O_HSYNC,
   output logic                  O_VSYNC,
   output logic                  O_DE
);

   localparam int CNT_W = $clog2(CHAR_W);

   if (CHAR_W < CHAR_W_MIN || CHAR_W > CHAR_W_MAX) begin : g_bad_char_w
      $error("CHAR_W out of range");
   end

   logic [CNT_W-1:0]         pix_cnt_q, pix_cnt_d;
   logic                     chr_ce_q;
   logic                     boundary;
   logic [1:0]               state_q, state_d;
   logic [VRAM_AW-1:0]       vram_a_q, vram_a_d;
   logic [CODE_W+ROW_W-1:0]  crom_a_q, crom_a_d;
   logic [ROW_W-1:0]         row_a_q, row_a_d;
   logic                     de_a_q, de_a_d, hs_a_q, hs_a_d, vs_a_q, vs_a_d;
   logic [COLOR_W-1:0]       fg_v_q, fg_v_d, bg_v_q, bg_v_d;
   logic [CHAR_W-1:0]        glyph_b_q, glyph_b_d;
   logic [COLOR_W-1:0]       fg_b_q, fg_b_d, bg_b_q, bg_b_d;
   logic                     de_b_q, de_b_d, hs_b_q, hs_b_d, vs_b_q, vs_b_d;
   logic                     unused_bits;

   assign unused_bits = ^{I_MA, I_RA};

   assign boundary = I_PIX_CE && (pix_cnt_q == CNT_W'(CHAR_W - 1));

   always_comb begin
      pix_cnt_d = pix_cnt_q;
      if (I_PIX_CE) pix_cnt_d = boundary ? '0 : pix_cnt_q + CNT_W'(1);
   end

   // A boundary always (re)starts the fetch, even if the previous one is
   // still in flight; stage A is captured here and consumed by later states.
   always_comb begin
      state_d   = state_q;
      vram_a_d  = vram_a_q;
      crom_a_d  = crom_a_q;
      row_a_d   = row_a_q;
      de_a_d    = de_a_q;
      hs_a_d    = hs_a_q;
      vs_a_d    = vs_a_q;
      fg_v_d    = fg_v_q;
      bg_v_d    = bg_v_q;
      glyph_b_d = glyph_b_q;
      fg_b_d    = fg_b_q;
      bg_b_d    = bg_b_q;
      de_b_d    = de_b_q;
      hs_b_d    = hs_b_q;
      vs_b_d    = vs_b_q;
      if (boundary) begin
         state_d  = FETCH_VADR;
         vram_a_d = I_MA[VRAM_AW-1:0];
         row_a_d  = I_RA[ROW_W-1:0];
         de_a_d   = I_DISPTMG;
         hs_a_d   = I_HSYNC;
         vs_a_d   = I_VSYNC;
      end else begin
         case (state_q)
            FETCH_VADR: begin
               state_d  = FETCH_CADR;
               fg_v_d   = I_VRAM_D[FG_LSB +: COLOR_W];
               bg_v_d   = I_VRAM_D[BG_LSB +: COLOR_W];
               crom_a_d = {I_VRAM_D[CODE_LSB +: CODE_W], row_a_q};
            end
            FETCH_CADR: begin
               state_d   = FETCH_DONE;
               glyph_b_d = de_a_q ? I_CROM_D : '0;
               fg_b_d    = de_a_q ? fg_v_q : '0;
               bg_b_d    = de_a_q ? bg_v_q : '0;
               de_b_d    = de_a_q;
               hs_b_d    = hs_a_q;
               vs_b_d    = vs_a_q;
            end
            default: state_d = FETCH_IDLE;
         endcase
      end
   end

   always_ff @(posedge I_CLK) begin
      if (!I_RSTn) begin
         pix_cnt_q <= '0;
         chr_ce_q  <= 1'b0;
         state_q   <= FETCH_IDLE;
         vram_a_q  <= '0;
         crom_a_q  <= '0;
         row_a_q   <= '0;
         de_a_q    <= 1'b0;
         hs_a_q    <= 1'b0;
         vs_a_q    <= 1'b0;
         fg_v_q    <= '0;
         bg_v_q    <= '0;
         glyph_b_q <= '0;
         fg_b_q    <= '0;
         bg_b_q    <= '0;
         de_b_q    <= 1'b0;
         hs_b_q    <= 1'b0;
         vs_b_q    <= 1'b0;
      end else begin
         pix_cnt_q <= pix_cnt_d;
         chr_ce_q  <= boundary;
         state_q   <= state_d;
         vram_a_q  <= vram_a_d;
         crom_a_q  <= crom_a_d;
         row_a_q   <= row_a_d;
         de_a_q    <= de_a_d;
         hs_a_q    <= hs_a_d;
         vs_a_q    <= vs_a_d;
         fg_v_q    <= fg_v_d;
         bg_v_q    <= bg_v_d;
         glyph_b_q <= glyph_b_d;
         fg_b_q    <= fg_b_d;
         bg_b_q    <= bg_b_d;
         de_b_q    <= de_b_d;
         hs_b_q    <= hs_b_d;
         vs_b_q    <= vs_b_d;
      end
   end

   assign O_CHR_CE = chr_ce_q;
   assign O_VRAM_A = vram_a_q;
   assign O_CROM_A = crom_a_q;

   crtc_pix_shifter #(
      .CHAR_W (CHAR_W)
   ) u_shifter (
      .clk        (I_CLK),
      .rst_n      (I_RSTn),
      .ce         (I_PIX_CE),
      .load       (boundary),
      .load_glyph (glyph_b_q),
      .load_fg    (fg_b_q),
      .load_bg    (bg_b_q),
      .load_de    (de_b_q),
      .load_hs    (hs_b_q),
      .load_vs    (vs_b_q),
      .color      (O_COLOR),
      .hsync      (O_HSYNC),
      .vsync      (O_VSYNC),
      .de         (O_DE)
   );

endmodule
